// File: rtl/vga_stream_output.sv
// vga_stream_output: VGA timing generator and RGB565 stream sink.
// Blanks on underflow/misalignment and relocks on the next start-of-packet.
module vga_stream_output #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FRONT  = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clock,
    input  logic        sreset_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    output logic        in_ready,
    output logic [15:0] vga_rgb,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_valid,
    output logic        underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int HS_BEG = H_ACTIVE + H_FRONT;
    localparam int HS_END = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FRONT;
    localparam int VS_END = V_ACTIVE + V_FRONT + V_SYNC;

    typedef enum logic [1:0] {
        ST_RESYNC,
        ST_WAIT,
        ST_ACTIVE
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [15:0]   rgb_q, rgb_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          valid_q, valid_d;
    logic          uf_q, uf_d;

    int   h_i;
    int   v_i;
    logic h_last;
    logic v_last;
    logic active;
    logic origin;

    assign h_i    = int'(h_q);
    assign v_i    = int'(v_q);
    assign h_last = (h_i == H_TOTAL - 1);
    assign v_last = (v_i == V_TOTAL - 1);
    assign active = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
    assign origin = (h_i == 0) && (v_i == 0);

    // Raster position counters; never disturbed by stream events.
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + 1'b1;
        end
    end

    // Pin values for the current position, registered one cycle later.
    always_comb begin
        hsync_d = ((h_i >= HS_BEG) && (h_i < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((v_i >= VS_BEG) && (v_i < VS_END)) ? SYNC_POL : ~SYNC_POL;
        valid_d = active;
    end

    // Stream lock FSM: handshake, pixel capture and error detection.
    always_comb begin
        state_d  = state_q;
        rgb_d    = '0;
        uf_d     = 1'b0;
        in_ready = 1'b0;
        unique case (state_q)
            ST_RESYNC: begin
                in_ready = !(in_valid && in_sop);
                if (in_valid && in_sop) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (h_last && v_last) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (active) begin
                    if (!in_valid) begin
                        uf_d    = 1'b1;
                        state_d = ST_RESYNC;
                    end else if (in_sop != origin) begin
                        uf_d    = 1'b1;
                        state_d = in_sop ? ST_WAIT : ST_RESYNC;
                    end else begin
                        in_ready = 1'b1;
                        rgb_d    = in_data;
                    end
                end
            end
            default: begin
                state_d = ST_RESYNC;
            end
        endcase
        if (!sreset_n) begin
            in_ready = 1'b0;
        end
    end

    // State, counters and registered pins.
    always_ff @(posedge clock) begin
        if (!sreset_n) begin
            state_q <= ST_RESYNC;
            h_q     <= '0;
            v_q     <= '0;
            rgb_q   <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            valid_q <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            valid_q <= valid_d;
            uf_q    <= uf_d;
        end
    end

    assign vga_rgb   = rgb_q;
    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign vga_valid = valid_q;
    assign underflow = uf_q;

endmodule

// File: tb/tb_vga_stream_output.sv
// tb_vga_stream_output: randomized scoreboard bench for vga_stream_output.
// Frame-level reference model predicts ready and registered pins per cycle.
module tb_vga_stream_output;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clock = 1'b0;
    logic        sreset_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_ready;
    logic [15:0] vga_rgb;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_valid;
    logic        underflow;

    vga_stream_output #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .clock(clock),
        .sreset_n(sreset_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_sop(in_sop),
        .in_ready(in_ready),
        .vga_rgb(vga_rgb),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .vga_valid(vga_valid),
        .underflow(underflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] rgb;
        logic        hs;
        logic        vs;
        logic        vl;
        logic        uf;
    } pins_t;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
    } pix_t;

    pins_t  exp_q[$];
    pix_t   src[$];
    int     checks = 0;
    int     failures = 0;
    longint t = 0;
    int     lock_frame = -1;
    int     drop_frame = -1;
    int     gap_pct = 0;

    // Monitor: compare registered pins against the scoreboard.
    always @(posedge clock) begin : mon
        pins_t e;
        pins_t a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.rgb = vga_rgb;
            a.hs  = vga_hsync;
            a.vs  = vga_vsync;
            a.vl  = vga_valid;
            a.uf  = underflow;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL pins @%0t got rgb=%h hs=%b vs=%b vl=%b uf=%b want rgb=%h hs=%b vs=%b vl=%b uf=%b",
                         $time, a.rgb, a.hs, a.vs, a.vl, a.uf,
                         e.rgb, e.hs, e.vs, e.vl, e.uf);
            end
        end
    end

    // One cycle of stimulus plus the reference model's prediction.
    task automatic step(input bit rst);
        pins_t       e;
        bit          rdy;
        bit          act;
        bit          org;
        bit          v;
        bit          s;
        logic [15:0] d;
        int          f;
        int          p;
        int          h;
        int          vv;
        @(negedge clock);
        f  = int'(t / FT);
        p  = int'(t % FT);
        h  = p % HT;
        vv = p / HT;
        v  = (src.size() > 0);
        if (v && f == drop_frame && h == 5 && vv == 0) v = 1'b0;
        if (v && gap_pct > 0 && $urandom_range(99) < gap_pct) v = 1'b0;
        s = v ? src[0].s : 1'($urandom_range(1));
        d = v ? src[0].d : 16'($urandom);
        sreset_n = !rst;
        in_valid = v;
        in_sop   = s;
        in_data  = d;
        e   = '0;
        rdy = 1'b0;
        if (rst) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            lock_frame = -1;
            t = 0;
        end else begin
            act  = (h < HA) && (vv < VA);
            org  = (h == 0) && (vv == 0);
            e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
            e.vs = !((vv >= VA + VF) && (vv < VA + VF + VS));
            e.vl = act;
            if (lock_frame < 0) begin
                rdy = !(v && s);
                if (v && s) lock_frame = int'((t + 1) / FT) + 1;
            end else if (f >= lock_frame && act) begin
                if (!v) begin
                    e.uf = 1'b1;
                    lock_frame = -1;
                end else if (s != org) begin
                    e.uf = 1'b1;
                    lock_frame = s ? int'((t + 1) / FT) + 1 : -1;
                end else begin
                    rdy   = 1'b1;
                    e.rgb = d;
                end
            end
            t++;
        end
        exp_q.push_back(e);
        #1;
        checks++;
        if (in_ready !== rdy) begin
            failures++;
            $display("FAIL ready @%0t got %b want %b", $time, in_ready, rdy);
        end
        if (in_ready && in_valid) void'(src.pop_front());
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic push_frame(input int tag, input int n);
        pix_t x;
        for (int i = 0; i < n; i++) begin
            x.d = 16'((tag << 8) | i);
            x.s = (i == 0);
            src.push_back(x);
        end
    endtask

    task automatic push_junk(input int n);
        pix_t x;
        for (int i = 0; i < n; i++) begin
            x.d = 16'($urandom);
            x.s = 1'b0;
            src.push_back(x);
        end
    endtask

    task automatic restart();
        src.delete();
        drop_frame = -1;
        gap_pct = 0;
        step(1'b1);
    endtask

    initial begin
        // Reset and bare sync timing.
        repeat (3) step(1'b1);
        run(2 * FT);

        // Continuous aligned stream.
        restart();
        for (int i = 0; i < 5; i++) push_frame(i, HA * VA);
        run(6 * FT);

        // Stream joins mid-frame.
        restart();
        push_junk(10);
        for (int i = 0; i < 4; i++) push_frame(16 + i, HA * VA);
        run(5 * FT);

        // Single-cycle valid drop at active pixel 5 of frame 2.
        restart();
        for (int i = 0; i < 6; i++) push_frame(32 + i, HA * VA);
        drop_frame = 2;
        run(6 * FT);
        drop_frame = -1;

        // Early sop at active pixel 20.
        restart();
        push_frame(48, HA * VA);
        push_frame(49, 20);
        for (int i = 0; i < 3; i++) push_frame(50 + i, HA * VA);
        run(6 * FT);

        // One-cycle reset during the active region.
        restart();
        for (int i = 0; i < 6; i++) push_frame(64 + i, HA * VA);
        run(150);
        step(1'b1);
        run(4 * FT);

        // Randomized frames, truncations, junk and gaps.
        for (int it = 0; it < 20; it++) begin
            restart();
            gap_pct = $urandom_range(3);
            for (int k = 0; k < 5; k++) begin
                case ($urandom_range(3))
                    0: push_frame(80 + k, 1 + $urandom_range(HA * VA - 2));
                    1: push_junk(1 + $urandom_range(4));
                    default: push_frame(80 + k, HA * VA);
                endcase
            end
            run(3 * FT);
        end

        repeat (2) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
